// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels, fixed access latency,
// byte-lane masked stores and right-justified loads from an internal word array.
module dmem_responder #(
    parameter int unsigned         DATA_W  = 64,
    parameter int unsigned         ADDR_W  = 64,
    parameter int unsigned         DEPTH   = 1024,
    parameter logic [ADDR_W-1:0]   BASE    = ADDR_W'(64'h8000_0000),
    parameter int unsigned         LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [3:0]        req_wdt_op,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SH_W  = OFF_W + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              wen_q,       wen_d;
    logic [3:0]        wdt_q,       wdt_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [OFF_W-1:0]  off_c;
    logic [OFF_W-1:0]  align_c;
    logic [ADDR_W-1:0] rel_c;
    logic [IDX_W-1:0]  idx_c;
    logic [NB-1:0]     size_lanes_c;
    logic [NB-1:0]     be_lanes_c;
    logic [DATA_W-1:0] size_bits_c;
    logic [DATA_W-1:0] be_bits_c;
    logic [SH_W-1:0]   shamt_c;
    logic              op_ok_c;
    logic              err_c;
    logic [DATA_W-1:0] word_c;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] merged_c;
    logic              mem_we_c;

    // Decode the captured request: size, alignment, range, load data and merged store word.
    always_comb begin
        off_c        = addr_q[OFF_W-1:0];
        rel_c        = addr_q - BASE;
        idx_c        = rel_c[OFF_W +: IDX_W];
        op_ok_c      = 1'b1;
        align_c      = '0;
        size_lanes_c = '0;
        case (wdt_q)
            4'b0001: begin size_lanes_c = NB'(8'h01); align_c = OFF_W'(0); end
            4'b0010: begin size_lanes_c = NB'(8'h03); align_c = OFF_W'(1); end
            4'b0100: begin size_lanes_c = NB'(8'h0F); align_c = OFF_W'(3); end
            4'b1000: begin size_lanes_c = NB'(8'hFF); align_c = OFF_W'(7); end
            default: op_ok_c = 1'b0;
        endcase
        be_lanes_c = size_lanes_c << off_c;
        for (int i = 0; i < NB; i++) begin
            size_bits_c[8*i +: 8] = {8{size_lanes_c[i]}};
            be_bits_c[8*i +: 8]   = {8{be_lanes_c[i]}};
        end
        // Below-BASE addresses wrap to huge offsets; the explicit compare keeps them from aliasing.
        err_c    = !op_ok_c
                 || ((off_c & align_c) != '0)
                 || (addr_q < BASE)
                 || ((rel_c >> OFF_W) >= ADDR_W'(DEPTH));
        shamt_c  = {off_c, 3'b000};
        word_c   = mem[idx_c];
        load_c   = (word_c >> shamt_c) & size_bits_c;
        merged_c = (word_c & ~be_bits_c) | ((wdata_q << shamt_c) & be_bits_c);
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdt_d       = wdt_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wen_d       = req_wen;
                    wdt_d       = req_wdt_op;
                    wdata_d     = req_wdata;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we_c    = wen_q && !err_c;
                    rsp_err_d   = err_c;
                    rsp_rdata_d = (err_c || wen_q) ? '0 : load_c;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdt_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdt_q       <= wdt_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is not reset; stores land only on the WAIT exit edge.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= merged_c;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_dmem_responder;

    localparam int unsigned LAT  = 2;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [3:0]  req_wdt_op;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DATA_W (64),
        .ADDR_W (64),
        .DEPTH  (1024),
        .BASE   (BASE),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdt_op(req_wdt_op),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [3:0]  wdt;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wen, input logic [63:0] addr, input logic [3:0] wdt,
                                input logic [63:0] wdata, input logic [63:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdt = wdt; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for rsp_valid; n returns cycles since the accept edge.
    task automatic wait_rsp(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) break;
        end
    endtask

    task automatic complete(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(req_ready), 64'd1);
    endtask

    task automatic transact(input logic wen, input logic [63:0] addr, input logic [3:0] wdt,
                            input logic [63:0] wdata, input logic [63:0] exp_rdata,
                            input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        check({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdt_op = wdt;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(n);
        check({tag, ".latency"}, 64'(n), 64'(LAT));
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".err"}, 64'(rsp_err), 64'(exp_err));
        check({tag, ".busy"}, 64'(req_ready), 64'd0);
        complete(tag);
    endtask

    initial begin
        int  n;
        bit  seen;

        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
        req_wdt_op = '0; req_wdata = '0; rsp_ready = 1'b0;

        // Stores, loads and error cases; expected values worked by hand.
        vecs.push_back(mk(1, BASE + 64'h10,   4'b1000, 64'h1122_3344_5566_7788, 64'h0, 0));
        vecs.push_back(mk(0, BASE + 64'h13,   4'b0001, 64'h0, 64'h55, 0));
        vecs.push_back(mk(0, BASE + 64'h16,   4'b0010, 64'h0, 64'h1122, 0));
        vecs.push_back(mk(1, BASE + 64'h11,   4'b0001, 64'hAB, 64'h0, 0));
        vecs.push_back(mk(0, BASE + 64'h10,   4'b1000, 64'h0, 64'h1122_3344_5566_AB88, 0));
        vecs.push_back(mk(1, BASE + 64'h14,   4'b0100, 64'hDEAD_BEEF, 64'h0, 0));
        vecs.push_back(mk(0, BASE + 64'h10,   4'b1000, 64'h0, 64'hDEAD_BEEF_5566_AB88, 0));
        vecs.push_back(mk(0, BASE + 64'h14,   4'b0100, 64'h0, 64'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, BASE + 64'h17,   4'b0001, 64'h0, 64'hDE, 0));
        vecs.push_back(mk(1, BASE + 64'h1FF8, 4'b1000, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, BASE + 64'h1,    4'b0010, 64'h0, 64'h0, 1));
        vecs.push_back(mk(1, 64'h7FFF_FFFC,   4'b0100, 64'h1234_5678, 64'h0, 1));
        vecs.push_back(mk(0, BASE + 64'h1FF8, 4'b1000, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, BASE + 64'h10,   4'b0011, 64'h0, 64'h0, 1));
        vecs.push_back(mk(1, BASE + 64'h10,   4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1));
        vecs.push_back(mk(0, BASE + 64'h10,   4'b1000, 64'h0, 64'hDEAD_BEEF_5566_AB88, 0));
        vecs.push_back(mk(0, BASE + 64'h2000, 4'b1000, 64'h0, 64'h0, 1));
        vecs.push_back(mk(1, BASE + 64'h2000, 4'b1000, 64'h5, 64'h0, 1));
        vecs.push_back(mk(0, BASE + 64'h13,   4'b0010, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, BASE + 64'h12,   4'b0100, 64'h0, 64'h0, 1));
        vecs.push_back(mk(1, BASE + 64'h12,   4'b0001, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, 0));
        vecs.push_back(mk(0, BASE + 64'h10,   4'b1000, 64'h0, 64'hDEAD_BEEF_5500_AB88, 0));

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst.req_ready", 64'(req_ready), 64'd1);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_rdata", rsp_rdata, 64'd0);
        check("rst.rsp_err", 64'(rsp_err), 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("idle.no_rsp", 64'(seen), 64'd0);

        foreach (vecs[i]) begin
            transact(vecs[i].wen, vecs[i].addr, vecs[i].wdt, vecs[i].wdata,
                     vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Backpressure with a request pending behind the held response
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'h10;
        req_wdt_op = 4'b1000; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(n);
        check("bp.latency", 64'(n), 64'(LAT));
        check("bp.rdata", rsp_rdata, 64'hDEAD_BEEF_5500_AB88);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'h13;
        req_wdt_op = 4'b0001; req_wdata = 64'hFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp.hold%0d.valid", k), 64'(rsp_valid), 64'd1);
            check($sformatf("bp.hold%0d.rdata", k), rsp_rdata, 64'hDEAD_BEEF_5500_AB88);
            check($sformatf("bp.hold%0d.err", k), 64'(rsp_err), 64'd0);
            check($sformatf("bp.hold%0d.ready", k), 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp.handshake.valid", 64'(rsp_valid), 64'd0);
        check("bp.handshake.ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        check("bp.pending_accepted", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        wait_rsp(n);
        check("bp.pending.latency", 64'(n), 64'(LAT));
        check("bp.pending.rdata", rsp_rdata, 64'h55);
        check("bp.pending.err", 64'(rsp_err), 64'd0);
        complete("bp.pending");

        // Reset in WAIT aborts a store without touching memory
        transact(1, BASE + 64'h20, 4'b1000, 64'h0123_4567_89AB_CDEF, 64'h0, 0, "mr.prior");
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 64'h20;
        req_wdt_op = 4'b0001; req_wdata = 64'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mr.in_wait", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr.rst.valid", 64'(rsp_valid), 64'd0);
        check("mr.rst.ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("mr.no_rsp", 64'(seen), 64'd0);
        check("mr.ready_after", 64'(req_ready), 64'd1);
        transact(0, BASE + 64'h20, 4'b1000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, "mr.readback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder that services load/store requests from the core's data memory port over a valid/ready request channel and a valid/ready response channel.
- Request latency is fixed and configurable.
- Writes are byte-lane masked, selected by the access-width one-hot; read data is returned right-justified, and the core's load extender applies any sign extension.
- Replaces the combinational memory model so the pipeline can be exercised against realistic stall behaviour.

Parameters:
- DATA_W, 64, data and word width in bits (8 byte lanes).
- ADDR_W, 64, request address width.
- DEPTH, 1024, number of DATA_W-bit words in the internal array.
- BASE, 64'h8000_0000, byte address mapped to word 0.
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_wen  input  1  1 = store, 0 = load.
- req_wdt_op  input  4  access width, one-hot: bit0 byte, bit1 half, bit2 word, bit3 double.
- req_wdata  input  DATA_W  store data, right-justified (low bytes used).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts response.
- rsp_rdata  output  DATA_W  load data, right-justified, zero above access width; 0 for stores and errors.
- rsp_err  output  1  access error (misaligned, out of range, or illegal wdt_op).

Behaviour:
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0. Array contents are not reset.
- Reset asserted mid-transaction aborts it immediately. A store is committed only at WAIT exit, so an aborted store leaves memory unchanged.
- State IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture addr, wen, wdt_op and wdata.
  - Load counter with LATENCY-1 and go to WAIT.
- State WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle.
  - When the counter equals 0, perform the access, register the result into rsp_rdata/rsp_err, set rsp_valid and go to RESP.
  - Net effect: rsp_valid rises exactly LATENCY cycles after the accept edge.
- State RESP:
  - req_ready = 0; rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_ready, clear rsp_valid and go to IDLE. A new request can be accepted no earlier than the following cycle (no overlap; one outstanding request).
- Size: bytes = 1, 2, 4 or 8 from wdt_op. Byte offset off = addr[2:0]; word index = (addr - BASE) >> 3.
- Error conditions (any of the following sets rsp_err = 1, suppresses the write and forces rsp_rdata = 0):
  - wdt_op not exactly one-hot;
  - addr not aligned to size (off mod bytes != 0);
  - addr < BASE;
  - word index >= DEPTH.
- Load: rsp_rdata = (word >> (8*off)) masked to size bytes; upper bits are zero.
- Store: byte mask = ((1<<bytes)-1) << off. Lanes in the mask take req_wdata << (8*off); all other lanes are unchanged.
- A store response always returns rsp_rdata = 0, with rsp_err as above.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around below BASE counts as out of range, not aliasing.
- The inputs req_* are ignored outside the accept cycle. Changing them while req_ready = 0 has no effect.
- rsp_ready held high continuously gives throughput of one request per LATENCY+2 cycles.

Test Plan:
- Reset/idle: assert rst=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; no response appears without a request.
- Double store then byte loads (LATENCY=2): store addr 0x8000_0010, wdt_op=4'b1000, wdata 0x1122_3344_5566_7788 -> rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0. Then load byte at 0x8000_0013 -> rsp_rdata=0x55. Load half at 0x8000_0016 -> 0x1122.
- Partial store masking: store byte 0xAB at 0x8000_0011 over the above -> subsequent double load at 0x8000_0010 returns 0x1122_3344_5566_AB88. Store word 0xDEAD_BEEF at 0x8000_0014 -> double load returns 0xDEAD_BEEF_5566_AB88.
- Errors:
  - half load at 0x8000_0001 -> rsp_err=1, rsp_rdata=0;
  - word store at 0x7FFF_FFFC -> rsp_err=1 and no array change;
  - wdt_op=4'b0011 -> rsp_err=1;
  - addr BASE+8*DEPTH -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; a req_valid presented meanwhile is not accepted. Raise rsp_ready -> handshake, then IDLE next cycle accepts the pending request.
- Reset mid-operation: accept a store of 0xFF to 0x8000_0020, assert rst=0 in WAIT -> rsp_valid never rises, req_ready=1 after release, and a load of 0x8000_0020 returns the prior value.
